// File: rtl/fb_arbiter_if.sv
// Bundles the display, host-write, fill-control and memory-port signals of the frame-buffer arbiter.
// The arbiter uses the slave modport; whatever drives the requests and models the memory uses master.
interface fb_arbiter_if #(
  parameter int data_width = 12,
  parameter int addr_width = 19
);
  logic                  disp_req;
  logic [addr_width-1:0] disp_addr;
  logic                  disp_valid;
  logic [data_width-1:0] disp_data;

  logic                  host_wr_valid;
  logic                  host_wr_ready;
  logic [addr_width-1:0] host_wr_addr;
  logic [data_width-1:0] host_wr_data;

  logic                  clr_start;
  logic [data_width-1:0] clr_color;
  logic                  clr_busy;
  logic                  clr_done;
  logic                  wr_err;

  logic                  mem_en;
  logic                  mem_we;
  logic [addr_width-1:0] mem_addr;
  logic [data_width-1:0] mem_wdata;
  logic [data_width-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, host_wr_valid, host_wr_addr, host_wr_data,
           clr_start, clr_color, mem_rdata,
    output disp_valid, disp_data, host_wr_ready, clr_busy, clr_done, wr_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, host_wr_valid, host_wr_addr, host_wr_data,
           clr_start, clr_color, mem_rdata,
    input  disp_valid, disp_data, host_wr_ready, clr_busy, clr_done, wr_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads win, then the frame-fill engine, then buffered host writes.
// Host writes queue in a small FIFO; a fill first drains that FIFO so earlier host writes land before it.
module fb_arbiter #(
  parameter int data_width = 12,
  parameter int addr_width = 19,
  parameter int horiz      = 640,
  parameter int vert       = 480,
  parameter int fifo_depth = 4
) (
  input logic clk,
  input logic rst_n,
  fb_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(fifo_depth);
  localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(horiz * vert - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, FILL, DONE} state_e;

  state_e                state_q;
  logic [addr_width-1:0] fill_cnt_q;
  logic [data_width-1:0] color_q;

  logic [addr_width-1:0] fifo_addr_q [fifo_depth];
  logic [data_width-1:0] fifo_data_q [fifo_depth];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W:0]        count_q;

  logic disp_valid_q;
  logic wr_err_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic head_in_range;

  assign fifo_full     = (count_q == (PTR_W+1)'(fifo_depth));
  assign fifo_empty    = (count_q == '0);
  assign bus.host_wr_ready = rst_n && !fifo_full && (state_q == IDLE);
  assign push          = bus.host_wr_valid && bus.host_wr_ready;
  assign pop           = !bus.disp_req && !fifo_empty && (state_q == IDLE || state_q == DRAIN);
  assign head_in_range = (fifo_addr_q[rd_ptr_q] <= LAST_ADDR);

  // Display reads bypass everything and reach the memory port in the same cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (bus.disp_req) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.disp_addr;
    end else if (state_q == FILL) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = fill_cnt_q;
      bus.mem_wdata = color_q;
    end else if (pop && head_in_range) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = fifo_addr_q[rd_ptr_q];
      bus.mem_wdata = fifo_data_q[rd_ptr_q];
    end
  end

  // NOTE: payload storage is not reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.host_wr_addr;
      fifo_data_q[wr_ptr_q] <= bus.host_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      color_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.clr_start) begin
          color_q    <= bus.clr_color;
          fill_cnt_q <= '0;
          state_q    <= DRAIN;
        end
        DRAIN: if (fifo_empty) state_q <= FILL;
        FILL: if (!bus.disp_req) begin
          // The counter stops on the last pixel rather than wrapping.
          if (fill_cnt_q == LAST_ADDR) state_q <= DONE;
          else                         fill_cnt_q <= fill_cnt_q + addr_width'(1);
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_valid_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      disp_valid_q <= bus.disp_req;
      wr_err_q     <= pop && !head_in_range;
    end
  end

  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = bus.mem_rdata;
  assign bus.wr_err     = wr_err_q;
  assign bus.clr_busy   = (state_q != IDLE);
  assign bus.clr_done   = (state_q == DONE);

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter on a 16x8 frame: a vector table, directed multi-cycle sequences and random traffic,
// all compared every cycle against a transaction-level model (write queue, fill progress, shadow memory).
module tb_fb_arbiter;

  localparam int DW    = 12;
  localparam int AW    = 19;
  localparam int H     = 16;
  localparam int V     = 8;
  localparam int NPIX  = H * V;
  localparam int IW    = 7;
  localparam int DEPTH = 4;

  localparam int M_IDLE  = 0;
  localparam int M_DRAIN = 1;
  localparam int M_FILL  = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fb_arbiter_if #(.data_width(DW), .addr_width(AW)) bus ();

  fb_arbiter #(
    .data_width(DW), .addr_width(AW), .horiz(H), .vert(V), .fifo_depth(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Pixel memory seen by the DUT's port.
  logic [DW-1:0] tb_mem [NPIX];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        if (bus.mem_addr < AW'(NPIX)) tb_mem[bus.mem_addr[IW-1:0]] <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= (bus.mem_addr < AW'(NPIX)) ? tb_mem[bus.mem_addr[IW-1:0]] : '0;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           m_q[$];
  int            m_mode;
  int            m_fill;
  logic [DW-1:0] m_color;
  bit            m_err;
  bit            m_rd;
  logic [DW-1:0] m_rd_data;
  logic [DW-1:0] ref_mem [NPIX];

  task automatic model_reset();
    m_q.delete();
    m_mode  = M_IDLE;
    m_fill  = 0;
    m_color = '0;
    m_err   = 1'b0;
    m_rd    = 1'b0;
  endtask

  // Observed outputs of the most recent cycle
  logic          o_en, o_we, o_ready, o_busy, o_done, o_err, o_valid;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_wdata, o_data;

  task automatic model_cycle();
    bit            pop, push, ready_e, e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            size_before;
    size_before = m_q.size();
    ready_e = (size_before < DEPTH) && (m_mode == M_IDLE);
    pop     = !bus.disp_req && size_before > 0 && (m_mode == M_IDLE || m_mode == M_DRAIN);
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (bus.disp_req) begin
      e_en = 1'b1; e_addr = bus.disp_addr;
    end else if (m_mode == M_FILL) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = AW'(m_fill); e_wdata = m_color;
    end else if (pop && m_q[0].addr < AW'(NPIX)) begin
      e_en = 1'b1; e_we = 1'b1; e_addr = m_q[0].addr; e_wdata = m_q[0].data;
    end
    check("mem_en",        32'(o_en),    32'(e_en));
    check("mem_we",        32'(o_we),    32'(e_we));
    check("mem_addr",      32'(o_addr),  32'(e_addr));
    check("mem_wdata",     32'(o_wdata), 32'(e_wdata));
    check("host_wr_ready", 32'(o_ready), 32'(ready_e));
    check("clr_busy",      32'(o_busy),  32'(m_mode != M_IDLE));
    check("clr_done",      32'(o_done),  32'(m_mode == M_DONE));
    check("wr_err",        32'(o_err),   32'(m_err));
    check("disp_valid",    32'(o_valid), 32'(m_rd));
    if (m_rd) check("disp_data", 32'(o_data), 32'(m_rd_data));

    m_rd = bus.disp_req;
    if (bus.disp_req && bus.disp_addr < AW'(NPIX)) m_rd_data = ref_mem[bus.disp_addr[IW-1:0]];
    if (e_en && e_we) ref_mem[e_addr[IW-1:0]] = e_wdata;
    m_err = pop && (m_q[0].addr >= AW'(NPIX));
    push  = bus.host_wr_valid && ready_e;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back('{addr: bus.host_wr_addr, data: bus.host_wr_data});
    case (m_mode)
      M_IDLE: if (bus.clr_start) begin
        m_mode = M_DRAIN; m_color = bus.clr_color; m_fill = 0;
      end
      M_DRAIN: if (size_before == 0) m_mode = M_FILL;
      M_FILL: if (!bus.disp_req) begin
        if (m_fill == NPIX - 1) m_mode = M_DONE;
        else m_fill++;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // One clock cycle: inputs are already set; sample at the falling edge, then step to just past the rising edge.
  task automatic tick();
    @(negedge clk);
    o_en = bus.mem_en; o_we = bus.mem_we; o_addr = bus.mem_addr; o_wdata = bus.mem_wdata;
    o_ready = bus.host_wr_ready; o_busy = bus.clr_busy; o_done = bus.clr_done;
    o_err = bus.wr_err; o_valid = bus.disp_valid; o_data = bus.disp_data;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.host_wr_valid = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
    bus.clr_start = 1'b0; bus.clr_color = '0;
  endtask

  typedef struct {
    logic          req;
    logic [AW-1:0] addr;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic          exp_valid_next;
    logic [DW-1:0] exp_data_next;
  } vec_t;

  vec_t vecs[6];
  wr_t  seen[$];
  int   done_cnt, fill_bad, fill_cnt, guard;
  bit   found;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    bus.mem_rdata = '0;
    for (int i = 0; i < NPIX; i++) begin
      tb_mem[i]  = DW'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[5] = 12'hABC; ref_mem[5] = 12'hABC;
    tb_mem[6] = 12'h123; ref_mem[6] = 12'h123;
    tb_mem[NPIX-1] = 12'h5A5; ref_mem[NPIX-1] = 12'h5A5;
    model_reset();

    vecs[0] = '{1'b1, AW'(5),      1'b1, AW'(5),      1'b1, 12'hABC};
    vecs[1] = '{1'b0, AW'(77),     1'b0, AW'(0),      1'b0, 12'h000};
    vecs[2] = '{1'b1, AW'(6),      1'b1, AW'(6),      1'b1, 12'h123};
    vecs[3] = '{1'b1, AW'(NPIX-1), 1'b1, AW'(NPIX-1), 1'b1, 12'h5A5};
    vecs[4] = '{1'b1, AW'(5),      1'b1, AW'(5),      1'b1, 12'hABC};
    vecs[5] = '{1'b0, AW'(0),      1'b0, AW'(0),      1'b0, 12'h000};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst host_wr_ready", 32'(bus.host_wr_ready), 32'd0);
    check("rst clr_busy",      32'(bus.clr_busy),      32'd0);
    check("rst mem_en",        32'(bus.mem_en),        32'd0);
    check("rst disp_valid",    32'(bus.disp_valid),    32'd0);
    check("rst clr_done",      32'(bus.clr_done),      32'd0);
    check("rst wr_err",        32'(bus.wr_err),        32'd0);
    rst_n = 1'b1;
    tick();
    check("ready after release", 32'(o_ready), 32'd1);

    // Display read table
    for (int i = 0; i < 6; i++) begin
      bus.disp_req  = vecs[i].req;
      bus.disp_addr = vecs[i].addr;
      tick();
      check("vec mem_en",   32'(o_en),   32'(vecs[i].exp_en));
      check("vec mem_we",   32'(o_we),   32'd0);
      check("vec mem_addr", 32'(o_addr), 32'(vecs[i].exp_addr));
      if (i > 0) begin
        check("vec disp_valid", 32'(o_valid), 32'(vecs[i-1].exp_valid_next));
        if (vecs[i-1].exp_valid_next) check("vec disp_data", 32'(o_data), 32'(vecs[i-1].exp_data_next));
      end
    end

    // Host writes held off by continuous display traffic, then released in order
    bus.disp_req = 1'b1; bus.disp_addr = AW'(3);
    for (int k = 0; k < DEPTH; k++) begin
      bus.host_wr_valid = 1'b1; bus.host_wr_addr = AW'(10 + k); bus.host_wr_data = DW'(12'h100 + k);
      tick();
      check("fifo fill ready", 32'(o_ready), 32'd1);
      check("fifo fill no write", 32'(o_we), 32'd0);
    end
    bus.host_wr_addr = AW'(99);
    tick();
    check("fifo full ready", 32'(o_ready), 32'd0);
    bus.host_wr_valid = 1'b0; bus.disp_req = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      tick();
      check("drain order we",   32'(o_we),    32'd1);
      check("drain order addr", 32'(o_addr),  32'(10 + k));
      check("drain order data", 32'(o_wdata), 32'(12'h100 + k));
    end
    tick();
    check("fifo empty idle", 32'(o_en), 32'd0);

    // Out-of-range host write is dropped with a wr_err pulse
    bus.host_wr_valid = 1'b1; bus.host_wr_addr = AW'(NPIX); bus.host_wr_data = 12'hEEE;
    tick();
    bus.host_wr_valid = 1'b0;
    tick();
    check("oor no access", 32'(o_en), 32'd0);
    tick();
    check("oor wr_err", 32'(o_err), 32'd1);
    bus.host_wr_valid = 1'b1; bus.host_wr_addr = AW'(20); bus.host_wr_data = 12'h321;
    tick();
    check("oor wr_err one cycle", 32'(o_err), 32'd0);
    bus.host_wr_valid = 1'b0;
    tick();
    check("after oor addr", 32'(o_addr), 32'd20);
    check("after oor data", 32'(o_wdata), 32'h321);

    // Queued host writes drain ahead of a full-frame fill
    bus.disp_req = 1'b1; bus.disp_addr = AW'(1);
    bus.host_wr_valid = 1'b1; bus.host_wr_addr = AW'(30); bus.host_wr_data = 12'h0A1;
    tick();
    bus.host_wr_addr = AW'(31); bus.host_wr_data = 12'h0A2;
    tick();
    bus.host_wr_valid = 1'b0;
    bus.clr_start = 1'b1; bus.clr_color = 12'h0F0;
    tick();
    bus.clr_start = 1'b0;
    tick();
    check("drain busy", 32'(o_busy), 32'd1);
    check("drain ready", 32'(o_ready), 32'd0);
    bus.disp_req = 1'b0;
    seen.delete();
    done_cnt = 0;
    guard = 0;
    while (done_cnt == 0 && guard < NPIX + 20) begin
      tick();
      guard++;
      if (o_en && o_we) seen.push_back('{addr: o_addr, data: o_wdata});
      if (o_done) done_cnt++;
      if (o_busy && o_ready) check("ready while busy", 32'(o_ready), 32'd0);
    end
    check("fill done seen", 32'(done_cnt), 32'd1);
    check("fill write count", 32'(seen.size()), 32'(NPIX + 2));
    if (seen.size() >= 3) begin
      check("first host write", 32'(seen[0].addr), 32'd30);
      check("second host write", 32'(seen[1].addr), 32'd31);
      check("first fill addr", 32'(seen[2].addr), 32'd0);
      fill_bad = 0;
      for (int i = 2; i < seen.size(); i++)
        if (seen[i].addr != AW'(i - 2) || seen[i].data != 12'h0F0) fill_bad++;
      check("fill sequence", 32'(fill_bad), 32'd0);
    end
    tick();
    check("busy after done", 32'(o_busy), 32'd0);
    check("done single pulse", 32'(o_done), 32'd0);

    // Reset in the middle of a fill aborts it; a new fill starts from 0
    bus.clr_start = 1'b1; bus.clr_color = 12'h333;
    tick();
    bus.clr_start = 1'b0;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 100) begin
      tick();
      guard++;
      if (o_en && o_we && o_addr == AW'(50)) found = 1'b1;
    end
    check("reached fill addr 50", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst busy",  32'(bus.clr_busy),      32'd0);
    check("mid rst ready", 32'(bus.host_wr_ready), 32'd0);
    check("mid rst en",    32'(bus.mem_en),        32'd0);
    check("mid rst we",    32'(bus.mem_we),        32'd0);
    check("mid rst done",  32'(bus.clr_done),      32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("no done after abort", 32'(o_done), 32'd0);
    bus.clr_start = 1'b1; bus.clr_color = 12'h444;
    tick();
    bus.clr_start = 1'b0;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 5) begin
      tick();
      guard++;
      if (o_en && o_we) begin
        found = 1'b1;
        check("restart fill addr", 32'(o_addr), 32'd0);
        check("restart fill data", 32'(o_wdata), 32'h444);
      end
    end
    check("restart fill seen", 32'(found), 32'd1);
    guard = 0;
    fill_cnt = 0;
    while (!o_done && guard < NPIX + 10) begin
      tick();
      guard++;
    end
    check("restart fill done", 32'(o_done), 32'd1);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.disp_req      = ($urandom_range(0, 2) == 0);
      bus.disp_addr     = AW'($urandom_range(0, NPIX - 1));
      bus.host_wr_valid = $urandom_range(0, 1) == 1;
      bus.host_wr_addr  = AW'($urandom_range(0, NPIX + 7));
      bus.host_wr_data  = DW'($urandom);
      bus.clr_start     = ($urandom_range(0, 199) == 0);
      bus.clr_color     = DW'($urandom);
      tick();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
